// File: rtl/regfile_arbiter.sv
// Two-requester round-robin front end for a register file: accepts one request at a
// time, issues it for one cycle, captures the read data and holds the response.
module regfile_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            ReqValid,
  output logic [1:0]            ReqReady,
  input  logic [3:0]            ReqOp,
  input  logic [2*ADDR_W-1:0]   ReqAddr1,
  input  logic [2*ADDR_W-1:0]   ReqAddr2,
  input  logic [2*ADDR_W-1:0]   ReqWAddr,
  input  logic [2*DATA_W-1:0]   ReqWData,
  output logic [2:0]            Sel,
  output logic [ADDR_W-1:0]     ReadRegister1,
  output logic [ADDR_W-1:0]     ReadRegister2,
  output logic [ADDR_W-1:0]     WriteRegister,
  output logic [DATA_W-1:0]     WriteData,
  input  logic [DATA_W-1:0]     ReadData1,
  input  logic [DATA_W-1:0]     ReadData2,
  output logic                  RspValid,
  input  logic                  RspReady,
  output logic                  RspId,
  output logic                  RspErr,
  output logic [DATA_W-1:0]     RspData1,
  output logic [DATA_W-1:0]     RspData2
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  typedef enum logic [1:0] {OP_READ1, OP_READ2, OP_WRITE, OP_WRRD} op_t;

  // One extra bit so the limit itself is representable even when NUM_REGS == 2**ADDR_W.
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(NUM_REGS);

  state_t              state, state_nxt;
  logic                ptr;
  op_t                 op_q;
  logic [ADDR_W-1:0]   addr1_q, addr2_q, waddr_q;
  logic [DATA_W-1:0]   wdata_q, data1_q, data2_q;
  logic                id_q, err_q;

  logic                win_b, accept, req_err, bad1, bad2, badw, drive;
  op_t                 req_op;
  logic [ADDR_W-1:0]   req_a1, req_a2, req_wa;
  logic [DATA_W-1:0]   req_wd;

  // ptr = 1 means B has priority when both requesters are valid.
  always_comb begin
    win_b  = ReqValid[1] & (~ReqValid[0] | ptr);
    accept = (state == IDLE) & (|ReqValid);
    req_op = op_t'(win_b ? ReqOp[3:2] : ReqOp[1:0]);
    req_a1 = win_b ? ReqAddr1[2*ADDR_W-1:ADDR_W] : ReqAddr1[ADDR_W-1:0];
    req_a2 = win_b ? ReqAddr2[2*ADDR_W-1:ADDR_W] : ReqAddr2[ADDR_W-1:0];
    req_wa = win_b ? ReqWAddr[2*ADDR_W-1:ADDR_W] : ReqWAddr[ADDR_W-1:0];
    req_wd = win_b ? ReqWData[2*DATA_W-1:DATA_W] : ReqWData[DATA_W-1:0];
    bad1   = {1'b0, req_a1} >= ADDR_LIMIT;
    bad2   = {1'b0, req_a2} >= ADDR_LIMIT;
    badw   = {1'b0, req_wa} >= ADDR_LIMIT;
    req_err = 1'b0;
    unique case (req_op)
      OP_READ1: req_err = bad1;
      OP_READ2: req_err = bad1 | bad2;
      OP_WRITE: req_err = badw;
      OP_WRRD:  req_err = bad1 | bad2 | badw;
    endcase
    ReqReady = 2'b00;
    if (state == IDLE && rst_n)
      ReqReady = win_b ? 2'b10 : {1'b0, ReqValid[0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    Sel       = 3'b000;
    drive     = 1'b0;
    unique case (state)
      IDLE:    if (accept) state_nxt = req_err ? RESP : ISSUE;
      ISSUE: begin
        drive = 1'b1;
        unique case (op_q)
          OP_READ1: Sel = 3'b010;
          OP_READ2: Sel = 3'b011;
          OP_WRITE: Sel = 3'b001;
          OP_WRRD:  Sel = 3'b100;
        endcase
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        drive     = 1'b1;
        state_nxt = RESP;
      end
      RESP:    if (RspReady) state_nxt = IDLE;
    endcase
  end

  assign ReadRegister1 = drive ? addr1_q : '0;
  assign ReadRegister2 = drive ? addr2_q : '0;
  assign WriteRegister = drive ? waddr_q : '0;
  assign WriteData     = drive ? wdata_q : '0;
  assign RspValid      = (state == RESP);
  assign RspId         = id_q;
  assign RspErr        = err_q;
  assign RspData1      = data1_q;
  assign RspData2      = data2_q;

  // Request capture on accept; read data is zeroed for fields the op does not read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= 1'b0;
      op_q    <= OP_READ1;
      addr1_q <= '0;
      addr2_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      data1_q <= '0;
      data2_q <= '0;
    end else if (state == IDLE && accept) begin
      ptr     <= ~win_b;
      op_q    <= req_op;
      addr1_q <= req_a1;
      addr2_q <= req_a2;
      waddr_q <= req_wa;
      wdata_q <= req_wd;
      id_q    <= win_b;
      err_q   <= req_err;
      if (req_err) begin
        data1_q <= '0;
        data2_q <= '0;
      end
    end else if (state == CAPTURE) begin
      data1_q <= (op_q == OP_WRITE) ? '0 : ReadData1;
      data2_q <= (op_q == OP_READ2 || op_q == OP_WRRD) ? ReadData2 : '0;
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a small behavioural register file attached.
module tb_regfile_arbiter;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 16;
  localparam logic [1:0] RD1 = 2'b00, RD2 = 2'b01, WR = 2'b10, WRRD = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0] ReqValid, ReqReady;
  logic [3:0] ReqOp;
  logic [2*ADDR_W-1:0] ReqAddr1, ReqAddr2, ReqWAddr;
  logic [2*DATA_W-1:0] ReqWData;
  logic [2:0] Sel;
  logic [ADDR_W-1:0] ReadRegister1, ReadRegister2, WriteRegister;
  logic [DATA_W-1:0] WriteData, ReadData1, ReadData2, RspData1, RspData2;
  logic RspValid, RspReady, RspId, RspErr;

  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] mem [16];
  bit mem_init = 1'b0;
  logic exp_b;

  regfile_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst_n(rst_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp),
    .ReqAddr1(ReqAddr1), .ReqAddr2(ReqAddr2), .ReqWAddr(ReqWAddr), .ReqWData(ReqWData),
    .Sel(Sel), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .WriteRegister(WriteRegister), .WriteData(WriteData),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .RspValid(RspValid), .RspReady(RspReady), .RspId(RspId), .RspErr(RspErr),
    .RspData1(RspData1), .RspData2(RspData2)
  );

  always #5 clk = ~clk;

  // Register file: reg i starts at 16'h1000+i, synchronous write, asynchronous read.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'h1000 + 16'(i);
      mem_init <= 1'b1;
    end else if (Sel == 3'b001 || Sel == 3'b100) begin
      mem[WriteRegister[3:0]] <= WriteData;
    end
  end

  assign ReadData1 = (ReadRegister1 < 5'd16) ? mem[ReadRegister1[3:0]] : 16'h0;
  assign ReadData2 = (ReadRegister2 < 5'd16) ? mem[ReadRegister2[3:0]] : 16'h0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int r, input logic v, input logic [1:0] op,
                               input logic [4:0] a1, input logic [4:0] a2,
                               input logic [4:0] wa, input logic [15:0] wd);
    ReqValid[r] = v;
    ReqOp[2*r +: 2] = op;
    ReqAddr1[5*r +: 5] = a1;
    ReqAddr2[5*r +: 5] = a2;
    ReqWAddr[5*r +: 5] = wa;
    ReqWData[16*r +: 16] = wd;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    ReqValid = 2'b11;
    ReqOp = '0;
    ReqAddr1 = '0;
    ReqAddr2 = '0;
    ReqWAddr = '0;
    ReqWData = '0;
    RspReady = 1'b1;
    rst_n = 1'b0;
    #7;
    // Reset values, with both requests valid to show ReqReady is held off
    checkOutput("rst_ready", 32'(ReqReady), 32'h0);
    checkOutput("rst_sel", 32'(Sel), 32'h0);
    checkOutput("rst_rspvalid", 32'(RspValid), 32'h0);
    checkOutput("rst_rsperr", 32'(RspErr), 32'h0);
    checkOutput("rst_rspid", 32'(RspId), 32'h0);
    checkOutput("rst_rspdata1", 32'(RspData1), 32'h0);
    checkOutput("rst_rr1", 32'(ReadRegister1), 32'h0);
    checkOutput("rst_wdata", 32'(WriteData), 32'h0);
    ReqValid = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous A WRITE and B READ2: A wins first after reset
    applyStimulus(0, 1'b1, WR, 5'd0, 5'd0, 5'd3, 16'hBEEF);
    applyStimulus(1, 1'b1, RD2, 5'd3, 5'd4, 5'd0, 16'h0);
    #1;
    checkOutput("arb_a_first", 32'(ReqReady), 32'h1);
    tick();
    ReqValid[0] = 1'b0;
    checkOutput("wr_sel", 32'(Sel), 32'h1);
    checkOutput("wr_waddr", 32'(WriteRegister), 32'h3);
    checkOutput("wr_wdata", 32'(WriteData), 32'hBEEF);
    checkOutput("wr_ready_busy", 32'(ReqReady), 32'h0);
    tick();
    checkOutput("wr_capture_sel", 32'(Sel), 32'h0);
    tick();
    checkOutput("wr_rspvalid", 32'(RspValid), 32'h1);
    checkOutput("wr_rspid", 32'(RspId), 32'h0);
    checkOutput("wr_rsperr", 32'(RspErr), 32'h0);
    checkOutput("wr_rspdata1", 32'(RspData1), 32'h0);
    checkOutput("wr_rspdata2", 32'(RspData2), 32'h0);
    tick();
    checkOutput("idle_rspvalid", 32'(RspValid), 32'h0);
    checkOutput("arb_b_second", 32'(ReqReady), 32'h2);
    tick();
    ReqValid[1] = 1'b0;
    checkOutput("rd2_sel", 32'(Sel), 32'h3);
    checkOutput("rd2_rr1", 32'(ReadRegister1), 32'h3);
    checkOutput("rd2_rr2", 32'(ReadRegister2), 32'h4);
    tick();
    checkOutput("rd2_capture_sel", 32'(Sel), 32'h0);
    checkOutput("rd2_capture_rr1", 32'(ReadRegister1), 32'h3);
    tick();
    checkOutput("rd2_rspvalid", 32'(RspValid), 32'h1);
    checkOutput("rd2_rspid", 32'(RspId), 32'h1);
    checkOutput("rd2_rspdata1", 32'(RspData1), 32'hBEEF);
    checkOutput("rd2_rspdata2", 32'(RspData2), 32'h1004);
    tick();

    // A READ1 of the register written above
    applyStimulus(0, 1'b1, RD1, 5'd3, 5'd0, 5'd0, 16'h0);
    #1;
    checkOutput("rd1_ready", 32'(ReqReady), 32'h1);
    tick();
    ReqValid[0] = 1'b0;
    checkOutput("rd1_sel", 32'(Sel), 32'h2);
    checkOutput("rd1_rr1", 32'(ReadRegister1), 32'h3);
    tick();
    tick();
    checkOutput("rd1_rspvalid", 32'(RspValid), 32'h1);
    checkOutput("rd1_rspid", 32'(RspId), 32'h0);
    checkOutput("rd1_rsperr", 32'(RspErr), 32'h0);
    checkOutput("rd1_rspdata1", 32'(RspData1), 32'hBEEF);
    checkOutput("rd1_rspdata2", 32'(RspData2), 32'h0);
    tick();

    // B READ2 with addr2 out of range: straight to an error response
    applyStimulus(1, 1'b1, RD2, 5'd5, 5'd17, 5'd0, 16'h0);
    #1;
    checkOutput("err_ready", 32'(ReqReady), 32'h2);
    tick();
    ReqValid[1] = 1'b0;
    checkOutput("err_sel", 32'(Sel), 32'h0);
    checkOutput("err_rspvalid", 32'(RspValid), 32'h1);
    checkOutput("err_rsperr", 32'(RspErr), 32'h1);
    checkOutput("err_rspid", 32'(RspId), 32'h1);
    checkOutput("err_rspdata1", 32'(RspData1), 32'h0);
    checkOutput("err_rspdata2", 32'(RspData2), 32'h0);
    tick();
    checkOutput("err_idle_rspvalid", 32'(RspValid), 32'h0);

    // A READ2 with the response stalled for 5 cycles while B waits
    applyStimulus(0, 1'b1, RD2, 5'd5, 5'd6, 5'd0, 16'h0);
    RspReady = 1'b0;
    #1;
    checkOutput("stall_ready", 32'(ReqReady), 32'h1);
    tick();
    ReqValid[0] = 1'b0;
    applyStimulus(1, 1'b1, WR, 5'd0, 5'd0, 5'd9, 16'h5A5A);
    checkOutput("stall_sel", 32'(Sel), 32'h3);
    tick();
    checkOutput("stall_capture_ready", 32'(ReqReady), 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("stall_rspvalid", 32'(RspValid), 32'h1);
      checkOutput("stall_rspdata1", 32'(RspData1), 32'h1005);
      checkOutput("stall_rspdata2", 32'(RspData2), 32'h1006);
      checkOutput("stall_rspid", 32'(RspId), 32'h0);
      checkOutput("stall_ready_off", 32'(ReqReady), 32'h0);
    end
    RspReady = 1'b1;
    tick();
    checkOutput("stall_release_rspvalid", 32'(RspValid), 32'h0);
    checkOutput("pending_b_ready", 32'(ReqReady), 32'h2);
    tick();
    ReqValid[1] = 1'b0;
    checkOutput("bwr_sel", 32'(Sel), 32'h1);
    checkOutput("bwr_waddr", 32'(WriteRegister), 32'h9);
    checkOutput("bwr_wdata", 32'(WriteData), 32'h5A5A);
    tick();
    tick();
    checkOutput("bwr_rspid", 32'(RspId), 32'h1);
    checkOutput("bwr_rspdata1", 32'(RspData1), 32'h0);
    tick();

    // A WRRD aborted by reset during CAPTURE; its write still lands
    applyStimulus(0, 1'b1, WRRD, 5'd9, 5'd2, 5'd2, 16'hCAFE);
    #1;
    checkOutput("wrrd_ready", 32'(ReqReady), 32'h1);
    tick();
    ReqValid[0] = 1'b0;
    checkOutput("wrrd_sel", 32'(Sel), 32'h4);
    checkOutput("wrrd_rr1", 32'(ReadRegister1), 32'h9);
    checkOutput("wrrd_rr2", 32'(ReadRegister2), 32'h2);
    checkOutput("wrrd_waddr", 32'(WriteRegister), 32'h2);
    checkOutput("wrrd_wdata", 32'(WriteData), 32'hCAFE);
    tick();
    checkOutput("wrrd_capture_sel", 32'(Sel), 32'h0);
    applyStimulus(0, 1'b1, RD1, 5'd2, 5'd0, 5'd0, 16'h0);
    applyStimulus(1, 1'b1, RD1, 5'd9, 5'd0, 5'd0, 16'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_sel", 32'(Sel), 32'h0);
    checkOutput("abort_rspvalid", 32'(RspValid), 32'h0);
    checkOutput("abort_rr1", 32'(ReadRegister1), 32'h0);
    checkOutput("abort_ready", 32'(ReqReady), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Both requesters held valid: alternating grants, 4 cycles apart
    for (int i = 0; i < 8; i++) begin
      exp_b = (i % 2) == 1;
      if (i > 0) tick();
      else #1;
      checkOutput("rr_ready", 32'(ReqReady), exp_b ? 32'h2 : 32'h1);
      checkOutput("rr_idle_rspvalid", 32'(RspValid), 32'h0);
      tick();
      checkOutput("rr_issue_sel", 32'(Sel), 32'h2);
      checkOutput("rr_issue_rr1", 32'(ReadRegister1), exp_b ? 32'h9 : 32'h2);
      checkOutput("rr_issue_ready", 32'(ReqReady), 32'h0);
      tick();
      checkOutput("rr_capture_sel", 32'(Sel), 32'h0);
      tick();
      checkOutput("rr_rspvalid", 32'(RspValid), 32'h1);
      checkOutput("rr_rspid", 32'(RspId), 32'(exp_b));
      checkOutput("rr_rspdata1", 32'(RspData1), exp_b ? 32'h5A5A : 32'hCAFE);
      checkOutput("rr_rspdata2", 32'(RspData2), 32'h0);
    end
    ReqValid = 2'b00;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
